// File: rtl/ring_freq_meter_pkg.sv
// Shared types, default parameters and the saturating-increment helper
// for the ring-oscillator frequency meter.
package ring_freq_meter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_GATE = 1'b1
   } state_e;

   localparam int DEF_CHANNELS    = 4;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_GATE_W      = 16;
   localparam int DEF_SYNC_STAGES = 2;

   // Widest counter the helper can serve; callers zero-extend into it.
   localparam int SAT_MAX_W = 32;

   function automatic logic [SAT_MAX_W-1:0] sat_inc(
      input logic [SAT_MAX_W-1:0] cur,
      input logic                 inc,
      input int unsigned          width
   );
      logic [SAT_MAX_W-1:0] max_v;
      max_v = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
      if (inc && (cur != max_v)) begin
         return cur + SAT_MAX_W'(1);
      end
      return cur;
   endfunction

endpackage

// File: rtl/ring_freq_meter_edge_sync.sv
// One ring input: multi-flop synchroniser followed by a rising-edge
// detector producing a single-cycle pulse per low-to-high transition.
module ring_edge_sync
   import ring_freq_meter_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_freq_meter.sv
// Gated multi-channel edge counter: counts ring-input rising edges over a
// programmable window of clk cycles and latches per-channel totals.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no window open; counters held at 0, edges discarded
//   ST_GATE | window open; gate timer counts down, edges accumulated
module ring_freq_meter
   import ring_freq_meter_pkg::*;
#(
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int GATE_W      = DEF_GATE_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       ring_in,
   input  logic [GATE_W-1:0]         gate_len,
   input  logic                      start,
   input  logic                      continuous,
   output logic [CHANNELS*CNT_W-1:0] value_out,
   output logic [CHANNELS-1:0]       overflow,
   output logic                      valid,
   output logic                      busy
);

   state_e                         state_q, state_d;
   logic [GATE_W-1:0]              gate_rem_q, gate_rem_d, gate_load;
   logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CHANNELS-1:0][CNT_W-1:0] value_q, value_d;
   logic [CHANNELS-1:0]            ovf_q, ovf_d, ovfl_q, ovfl_d;
   logic [CHANNELS-1:0]            sat_hit, edge_w;
   logic                           valid_q, valid_d;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
      ring_edge_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk        (clk),
         .rst        (rst),
         .d          (ring_in[g]),
         .edge_pulse (edge_w[g])
      );
   end

   // Gate timer runs down from len-1; a zero length still opens one cycle.
   assign gate_load = (gate_len == '0) ? '0 : gate_len - GATE_W'(1);

   always_comb begin
      cnt_inc = '0;
      sat_hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_inc[i] = CNT_W'(sat_inc(SAT_MAX_W'(cnt_q[i]), edge_w[i], CNT_W));
         sat_hit[i] = edge_w[i] && (cnt_q[i] == {CNT_W{1'b1}});
      end
   end

   always_comb begin
      state_d    = state_q;
      gate_rem_d = gate_rem_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      value_d    = value_q;
      ovfl_d     = ovfl_q;
      valid_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            ovf_d = '0;
            if (start) begin
               gate_rem_d = gate_load;
               state_d    = ST_GATE;
            end
         end
         ST_GATE: begin
            if (gate_rem_q == '0) begin
               // Closing cycle: this cycle's edges belong to the closing window.
               value_d = cnt_inc;
               ovfl_d  = ovf_q | sat_hit;
               cnt_d   = '0;
               ovf_d   = '0;
               valid_d = 1'b1;
               if (continuous) begin
                  gate_rem_d = gate_load;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d      = cnt_inc;
               ovf_d      = ovf_q | sat_hit;
               gate_rem_d = gate_rem_q - GATE_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gate_rem_q <= '0;
         cnt_q      <= '0;
         ovf_q      <= '0;
         value_q    <= '0;
         ovfl_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_rem_q <= gate_rem_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         value_q    <= value_d;
         ovfl_q     <= ovfl_d;
         valid_q    <= valid_d;
      end
   end

   assign value_out = value_q;
   assign overflow  = ovfl_q;
   assign valid     = valid_q;
   assign busy      = (state_q == ST_GATE);

endmodule

// File: tb/tb_ring_freq_meter.sv
// Directed bench for ring_freq_meter (4 channels, 4-bit counts so that
// saturation is reachable inside short windows).
module tb_ring_freq_meter;

   localparam int CH    = 4;
   localparam int CNT_W = 4;
   localparam int GW    = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [CH-1:0]     ring_in;
   logic [GW-1:0]     gate_len;
   logic              start;
   logic              continuous;
   logic [CH*CNT_W-1:0] value_out;
   logic [CH-1:0]     overflow;
   logic              valid;
   logic              busy;

   int n_chk = 0;
   int n_bad = 0;
   int ph = 0;
   int pat_sel = 0;
   logic [CH-1:0] ring_static = '0;

   ring_freq_meter #(
      .CHANNELS    (CH),
      .CNT_W       (CNT_W),
      .GATE_W      (GW),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ring_in    (ring_in),
      .gate_len   (gate_len),
      .start      (start),
      .continuous (continuous),
      .value_out  (value_out),
      .overflow   (overflow),
      .valid      (valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ring(p) is sampled at the p-th edge after start; rises counted iff 0 <= p <= len-2
   function automatic logic [CH-1:0] ring_pat(input int sel, input int p);
      logic [CH-1:0] r;
      r = '0;
      case (sel)
         1: begin
            r[0] = ((p / 5) % 2) != 0;
            r[1] = ((p / 10) % 2) != 0;
            r[2] = 1'b1;
         end
         2: begin
            r[0] = (p % 2) != 0;
            r[1] = ((p / 5) % 2) != 0;
            r[2] = (p == 48) || (p == 50) || (p == 98) || (p == 100);
         end
         3: r = ((p % 2) != 0) ? '1 : '0;
         default: r = ring_static;
      endcase
      return r;
   endfunction

   function automatic int ch_val(input int i);
      return int'(value_out[i*CNT_W +: CNT_W]);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      ph++;
      ring_in = ring_pat(pat_sel, ph);
   endtask

   task automatic settle(input logic [CH-1:0] val, input int n);
      pat_sel     = 0;
      ring_static = val;
      ring_in     = val;
      repeat (n) step();
   endtask

   task automatic begin_window(input int sel, input int len, input logic cont);
      ph         = 0;
      pat_sel    = sel;
      ring_in    = ring_pat(sel, 0);
      gate_len   = GW'(len);
      continuous = cont;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic one_shot_run(input string tag);
      int nv, vph, v0, v1, v2, v3, vo;
      settle(4'b0100, 5);
      begin_window(1, 100, 1'b0);
      check_val({tag, "_busy_rise"}, int'(busy), 1);
      nv = 0; vph = 0; v0 = 0; v1 = 0; v2 = 0; v3 = 0; vo = 0;
      for (int k = 0; k < 120; k++) begin
         step();
         if (ph == 100) check_val({tag, "_busy_last"}, int'(busy), 1);
         if (valid) begin
            nv++;
            vph = ph;
            v0 = ch_val(0); v1 = ch_val(1); v2 = ch_val(2); v3 = ch_val(3);
            vo = int'(overflow);
         end
      end
      check_val({tag, "_nvalid"}, nv, 1);
      check_val({tag, "_valid_cycle"}, vph, 101);
      check_val({tag, "_ch0"}, v0, 10);
      check_val({tag, "_ch1"}, v1, 5);
      check_val({tag, "_ch2"}, v2, 0);
      check_val({tag, "_ch3"}, v3, 0);
      check_val({tag, "_ovf"}, vo, 0);
      check_val({tag, "_busy_end"}, int'(busy), 0);
      check_val({tag, "_ch0_hold"}, ch_val(0), 10);
   endtask

   initial begin
      int nv, nb;
      int exp_ph[4] = '{51, 101, 151, 201};
      int exp_c2[4] = '{1, 2, 1, 0};
      int exp_g[3]  = '{101, 141, 181};

      rst = 1'b1; start = 1'b0; continuous = 1'b0; gate_len = '0; ring_in = '0;

      // reset, then idle with toggling inputs
      pat_sel = 3;
      repeat (3) step();
      rst = 1'b0;
      step();
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_valid", int'(valid), 0);
      check_val("rst_value", int'(value_out), 0);
      check_val("rst_ovf", int'(overflow), 0);
      nv = 0; nb = 0;
      repeat (30) begin
         step();
         if (valid) nv++;
         if (busy) nb++;
      end
      check_val("idle_nvalid", nv, 0);
      check_val("idle_nbusy", nb, 0);
      check_val("idle_value", int'(value_out), 0);

      one_shot_run("oneshot");

      // continuous with saturation, boundary edges, then continuous dropped
      settle(4'b0000, 5);
      begin_window(2, 50, 1'b1);
      nv = 0;
      while (ph < 260) begin
         step();
         if (ph == 170) continuous = 1'b0;
         if (valid) begin
            if (nv < 4) begin
               check_val($sformatf("cont_w%0d_cycle", nv), ph, exp_ph[nv]);
               check_val($sformatf("cont_w%0d_ch0", nv), ch_val(0), 15);
               check_val($sformatf("cont_w%0d_ovf0", nv), int'(overflow[0]), 1);
               check_val($sformatf("cont_w%0d_ch1", nv), ch_val(1), 5);
               check_val($sformatf("cont_w%0d_ovf1", nv), int'(overflow[1]), 0);
               check_val($sformatf("cont_w%0d_ch2", nv), ch_val(2), exp_c2[nv]);
               check_val($sformatf("cont_w%0d_ch3", nv), ch_val(3), 0);
            end
            nv++;
         end
      end
      check_val("cont_nvalid", nv, 4);
      check_val("cont_busy_end", int'(busy), 0);

      // reset mid-window while previous results are nonzero
      settle(4'b0000, 5);
      check_val("pre_rst_ch0", ch_val(0), 15);
      begin_window(1, 100, 1'b0);
      while (ph < 60) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("midrst_busy", int'(busy), 0);
      check_val("midrst_valid", int'(valid), 0);
      check_val("midrst_value", int'(value_out), 0);
      check_val("midrst_ovf", int'(overflow), 0);
      nv = 0; nb = 0;
      repeat (150) begin
         step();
         if (valid) nv++;
         if (busy) nb++;
      end
      check_val("midrst_nvalid", nv, 0);
      check_val("midrst_nbusy", nb, 0);
      one_shot_run("fresh");

      // gate_len 0 and 1: one-cycle windows, valid every cycle
      settle(4'b0000, 5);
      begin_window(0, 0, 1'b1);
      nv = 0; nb = 0;
      repeat (10) begin
         step();
         if (valid) nv++;
         if (busy) nb++;
      end
      check_val("len0_nvalid", nv, 10);
      check_val("len0_nbusy", nb, 10);
      gate_len = GW'(1);
      nv = 0;
      repeat (10) begin
         step();
         if (valid) nv++;
      end
      check_val("len1_nvalid", nv, 10);
      continuous = 1'b0;
      step();
      check_val("len1_stop_busy", int'(busy), 0);
      check_val("len1_stop_valid", int'(valid), 1);
      step();
      check_val("len1_after_valid", int'(valid), 0);

      // gate_len change mid-window only applies at the next load
      settle(4'b0000, 5);
      begin_window(0, 100, 1'b1);
      nv = 0;
      while (ph < 250) begin
         step();
         if (ph == 30) gate_len = GW'(40);
         if (ph == 150) continuous = 1'b0;
         if (valid) begin
            if (nv < 3) check_val($sformatf("glen_v%0d_cycle", nv), ph, exp_g[nv]);
            nv++;
         end
      end
      check_val("glen_nvalid", nv, 3);
      check_val("glen_busy_end", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
